mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised memory-port arbiter that lets NUM_CH requesters share the single memory port presented by the DUT harness (address, dataToMemory, writeEnable, dataFromMemory). It grants one request per cycle round-robin, drives registered memory-side signals, and routes read data back to the issuing channel after a fixed memory latency. It replaces the single-master direct hookup to memory in the test top.

## Interface
Parameters:
- NUM_CH, 4: number of requester channels (2..8)
- ADDR_W, 16: address width
- DATA_W, 16: data width
- READ_LAT, 2: cycles from the memory sampling address to dataFromMemory valid (1..4)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- chReq  in  NUM_CH  per-channel request, held until granted
- chWe  in  NUM_CH  per-channel write (1) / read (0)
- chAddr  in  NUM_CH x ADDR_W  per-channel address
- chWdata  in  NUM_CH x DATA_W  per-channel write data
- chGnt  out  NUM_CH  one-hot grant, combinational from chReq and pointer
- chRvalid  out  NUM_CH  one-hot read-data valid, registered
- chRdata  out  DATA_W  read data broadcast to all channels, registered
- address  out  ADDR_W  memory address, registered
- dataToMemory  out  DATA_W  memory write data, registered
- writeEnable  out  1  memory write strobe, registered
- dataFromMemory  in  DATA_W  memory read data

## Operation
- Accept: a transfer occurs in cycle t when chReq[i] and chGnt[i] are both 1. At most one chGnt bit is set per cycle; none when chReq == 0.
- Arbitration: search starts at channel (lastGnt+1) mod NUM_CH and wraps; the first requester wins. lastGnt updates only on an accept.
- Issue: on an accept in cycle t, address/dataToMemory/writeEnable take chAddr[i]/chWdata[i]/chWe[i] at the end of t. writeEnable is 1 for exactly one cycle per write. With no accept, writeEnable is 0 and address/dataToMemory hold their last values.
- Read tracking: a READ_LAT+1 deep shift pipeline of {valid, channel id}. An accepted read enters the pipeline; writes enter it as invalid. At the tail, chRdata <= dataFromMemory and chRvalid[id] <= 1 for one cycle.
- Reads and writes from any channels may be back to back, every cycle. Completions return in issue order.
- Requesters must hold chWe/chAddr/chWdata stable while chReq=1 and not granted. Dropping chReq before grant is legal and withdraws the request.

## Timing
- Reset (reset=0 at an edge): address=0, dataToMemory=0, writeEnable=0, chRvalid=0, chRdata=0, and lastGnt=NUM_CH-1, so channel 0 has first priority. Pipeline valid bits are cleared.
- Reset mid-operation: in-flight reads are discarded. No chRvalid is asserted for them, including after reset deassertion.
- Grant latency: 0 cycles (combinational chGnt).
- Memory issue: one cycle after accept.
- Read-data latency: an accept in cycle t gives chRvalid at cycle t+2+READ_LAT.
- Throughput: one transfer per cycle sustained. All channels requesting continuously receive grants in strict rotation, for example 0,1,2,3,0…
- Single requester: granted every cycle while it requests.

## Configuration
- MEM_ARB_STATS_EN defined:
  - Adds input clearStats (1 bit).
  - Adds output grantCount (NUM_CH x 16): a per-channel count of accepts that saturates at 16'hFFFF.
  - Counters reset to 0 on reset and on clearStats=1.
  - If clearStats and an accept occur in the same cycle, the clear wins and the counter becomes 0.
- MEM_ARB_STATS_EN not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package mem_arb_pkg holds:
  - MAX_CH=8 and MAX_READ_LAT=4
  - typedef ch_id_t (logic [2:0])
  - typedef rd_tag_t (struct {valid, ch_id_t id})
- Sub-module mem_arb_rr: round-robin picker holding lastGnt. Inputs are clk, reset, req vector and accept; outputs are the one-hot grant and the encoded ch_id_t.
- Top mem_arbiter contains the issue registers, the rd_tag_t pipeline and the optional stats.

## Test plan
- Reset release with all chReq=0 -> all outputs 0 and writeEnable stays 0 for 10 cycles.
- chReq=4'b1111, all writes, chAddr[i]=i:
  - grants in order 0,1,2,3,0
  - address sequence 0,1,2,3,0 one cycle later
  - writeEnable held at 1
- Channel 2 reads address 0x0010, memory model returns 0xBEEF, READ_LAT=2 -> chRvalid=4'b0100 with chRdata=0xBEEF exactly 4 cycles after accept.
- Channel 1 read accepted, then reset pulsed one cycle later -> no chRvalid ever asserted for it; next grant after reset goes to channel 0.
- Back-to-back reads ch0 then ch3 with READ_LAT=1 -> chRvalid 4'b0001 then 4'b1000 on consecutive cycles with the correct data.
- With MEM_ARB_STATS_EN: 70000 consecutive grants to ch0 -> grantCount[0]=16'hFFFF; clearStats=1 -> 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared limits and read-tag types for the memory-port arbiter
//
// Purpose: common definitions imported by mem_arb_rr and mem_arbiter.
//   MAX_CH       : largest supported channel count (channel ids fit in ch_id_t)
//   MAX_READ_LAT : largest supported memory read latency
//   ch_id_t      : encoded channel number
//   rd_tag_t     : one read-tracking pipeline slot {valid, channel id}

package mem_arb_pkg;

  localparam int MAX_CH       = 8;
  localparam int MAX_READ_LAT = 4;

  typedef logic [2:0] ch_id_t;

  typedef struct packed {
    logic   valid;
    ch_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - round-robin picker holding the last granted channel
//
// Purpose: combinational one-hot grant; search starts one past the last
// accepted channel and wraps. The pointer moves only on an accept.
// Ports:
//   clk, reset : clock, synchronous active-low reset (pointer -> NUM_CH-1)
//   req_i      : per-channel request vector
//   accept_i   : a granted request was taken this cycle
//   gnt_o      : one-hot grant (zero when req_i is zero)
//   gnt_id_o   : encoded index of the granted channel

module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              accept_i,
  output logic [NUM_CH-1:0] gnt_o,
  output ch_id_t            gnt_id_o
);

  ch_id_t            last_q;
  ch_id_t            last_d;
  logic [NUM_CH-1:0] upper_mask;
  logic [NUM_CH-1:0] req_upper;

  // Requests strictly above the last winner take priority; if none, the
  // lowest requester overall wins (the wrap-around). x & -x isolates the
  // lowest set bit.
  always_comb begin
    upper_mask = ~((NUM_CH'(2) << last_q) - NUM_CH'(1));
    req_upper  = req_i & upper_mask;
    if (req_upper != '0) begin
      gnt_o = req_upper & (~req_upper + NUM_CH'(1));
    end else begin
      gnt_o = req_i & (~req_i + NUM_CH'(1));
    end
    gnt_id_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_o[c]) begin
        gnt_id_o = ch_id_t'(c);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept_i) begin
      last_d = gnt_id_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= ch_id_t'(NUM_CH - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port among NUM_CH requesters
//
// Purpose: grants one request per cycle, registers the memory-side signals,
// and returns read data to the issuing channel after READ_LAT cycles.
// Optional build macro: MEM_ARB_STATS_EN adds clearStats / grantCount.
// Ports:
//   clk, reset         : clock, synchronous active-low reset
//   clearStats         : (MEM_ARB_STATS_EN) zero all grant counters
//   grantCount         : (MEM_ARB_STATS_EN) per-channel saturating accept count
//   chReq/chWe         : per-channel request and write(1)/read(0)
//   chAddr/chWdata     : per-channel address and write data
//   chGnt              : combinational one-hot grant
//   chRvalid/chRdata   : registered read completion (one-hot) and broadcast data
//   address/dataToMemory/writeEnable : registered memory port
//   dataFromMemory     : memory read data

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef MEM_ARB_STATS_EN
  input  logic                          clearStats,
  output logic [NUM_CH-1:0][15:0]       grantCount,
`endif
  input  logic [NUM_CH-1:0]             chReq,
  input  logic [NUM_CH-1:0]             chWe,
  input  logic [NUM_CH-1:0][ADDR_W-1:0] chAddr,
  input  logic [NUM_CH-1:0][DATA_W-1:0] chWdata,
  output logic [NUM_CH-1:0]             chGnt,
  output logic [NUM_CH-1:0]             chRvalid,
  output logic [DATA_W-1:0]             chRdata,
  output logic [ADDR_W-1:0]             address,
  output logic [DATA_W-1:0]             dataToMemory,
  output logic                          writeEnable,
  input  logic [DATA_W-1:0]             dataFromMemory
);

  logic [NUM_CH-1:0] gnt;
  ch_id_t            gnt_id;
  logic              accept;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  // Slot 0 is loaded at the accept edge; slot READ_LAT lines up with the
  // cycle in which dataFromMemory holds that read's data.
  rd_tag_t [READ_LAT:0] pipe_q, pipe_d;
  rd_tag_t              tail;

  logic [NUM_CH-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  mem_arb_rr #(.NUM_CH(NUM_CH)) u_rr (
    .clk      (clk),
    .reset    (reset),
    .req_i    (chReq),
    .accept_i (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign chGnt  = gnt;
  assign accept = |(chReq & gnt);

  // One-hot AND-OR mux of the winning channel's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt[c]) begin
        sel_addr  = sel_addr | chAddr[c];
        sel_wdata = sel_wdata | chWdata[c];
        sel_we    = sel_we | chWe[c];
      end
    end
  end

  always_comb begin
    address_d = address_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    if (accept) begin
      address_d = sel_addr;
      wdata_d   = sel_wdata;
      we_d      = sel_we;
    end
  end

  // Writes enter as invalid slots so completions stay in issue order.
  always_comb begin
    pipe_d          = '0;
    pipe_d[0].valid = accept & ~sel_we;
    pipe_d[0].id    = gnt_id;
    for (int s = 1; s <= READ_LAT; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  assign tail = pipe_q[READ_LAT];

  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (tail.valid) begin
      rvalid_d = NUM_CH'(1) << tail.id;
      rdata_d  = dataFromMemory;
    end
  end

  // Reset clears the tag pipeline, so reads in flight never complete.
  always_ff @(posedge clk) begin
    if (!reset) begin
      address_q <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      pipe_q    <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      address_q <= address_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      pipe_q    <= pipe_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign address      = address_q;
  assign dataToMemory = wdata_q;
  assign writeEnable  = we_q;
  assign chRvalid     = rvalid_q;
  assign chRdata      = rdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [NUM_CH-1:0][15:0] cnt_q, cnt_d;

  // A clear in the same cycle as an accept wins.
  always_comb begin
    cnt_d = cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (clearStats) begin
        cnt_d[c] = '0;
      end else if (gnt[c] && chReq[c] && (cnt_q[c] != 16'hFFFF)) begin
        cnt_d[c] = cnt_q[c] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grantCount = cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter against a reference model

module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [N-1:0]          chReq, chWe;
  logic [N-1:0][AW-1:0]  chAddr;
  logic [N-1:0][DW-1:0]  chWdata;

  logic [N-1:0]  gnt_a, rv_a, gnt_b, rv_b;
  logic [DW-1:0] rd_a, rd_b, wd_a, wd_b, dfm_a, dfm_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          we_a, we_b;
`ifdef MEM_ARB_STATS_EN
  logic                 clearStats;
  logic [N-1:0][15:0]   cnt_a, cnt_b;
`endif

  // Instance a: READ_LAT=2, instance b: READ_LAT=1, same requester stimulus.
  mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) u_dut_a (
    .clk(clk), .reset(reset),
`ifdef MEM_ARB_STATS_EN
    .clearStats(clearStats), .grantCount(cnt_a),
`endif
    .chReq(chReq), .chWe(chWe), .chAddr(chAddr), .chWdata(chWdata),
    .chGnt(gnt_a), .chRvalid(rv_a), .chRdata(rd_a),
    .address(addr_a), .dataToMemory(wd_a), .writeEnable(we_a),
    .dataFromMemory(dfm_a)
  );

  mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut_b (
    .clk(clk), .reset(reset),
`ifdef MEM_ARB_STATS_EN
    .clearStats(clearStats), .grantCount(cnt_b),
`endif
    .chReq(chReq), .chWe(chWe), .chAddr(chAddr), .chWdata(chWdata),
    .chGnt(gnt_b), .chRvalid(rv_b), .chRdata(rd_b),
    .address(addr_b), .dataToMemory(wd_b), .writeEnable(we_b),
    .dataFromMemory(dfm_b)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 16) ? 16'hBEEF : (DW'(i * 37) ^ 16'h5A5A);
  endfunction

  // Memory harnesses: address sampled at an edge, data valid READ_LAT cycles on.
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] pa0, pa1, pb0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
    end else if (we_a) begin
      mem_a[addr_a[7:0]] <= wd_a;
    end
    pa0 <= mem_a[addr_a[7:0]];
    pa1 <= pa0;
  end
  assign dfm_a = pa1;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
    end else if (we_b) begin
      mem_b[addr_b[7:0]] <= wd_b;
    end
    pb0 <= mem_b[addr_b[7:0]];
  end
  assign dfm_b = pb0;

  // Reference model state
  int            m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic          m_we;
  logic [DW-1:0] refmem [256];
  int            r_cyc [16];
  int            r_ch  [16];
  logic [DW-1:0] r_d   [16];
  bit            r_va  [16];
  bit            r_vb  [16];
  int            m_cnt [N];
  logic [N-1:0]  g_last;
  int            cyc;
  int            n_vec;
  int            n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_addr = '0;
    m_wd   = '0;
    m_we   = 1'b0;
    for (int i = 0; i < 256; i++) refmem[i] = init_word(i);
    for (int i = 0; i < 16; i++) begin
      r_va[i] = 1'b0;
      r_vb[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, move past the rising edge.
  task automatic tick();
    int           ia, ib, gi;
    logic [N-1:0] eg, erv;
    @(negedge clk);
    chk("we_a", we_a, m_we);
    chk("addr_a", addr_a, m_addr);
    chk("wdata_a", wd_a, m_wd);
    chk("we_b", we_b, m_we);
    chk("addr_b", addr_b, m_addr);
    chk("wdata_b", wd_b, m_wd);

    ia  = (cyc - 4) & 15;
    erv = '0;
    if (r_va[ia] && r_cyc[ia] == cyc - 4) begin
      erv = N'(1) << r_ch[ia];
      chk("rdata_a", rd_a, r_d[ia]);
      r_va[ia] = 1'b0;
    end
    chk("rvalid_a", rv_a, erv);

    ib  = (cyc - 3) & 15;
    erv = '0;
    if (r_vb[ib] && r_cyc[ib] == cyc - 3) begin
      erv = N'(1) << r_ch[ib];
      chk("rdata_b", rd_b, r_d[ib]);
      r_vb[ib] = 1'b0;
    end
    chk("rvalid_b", rv_b, erv);

    eg = '0;
    gi = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (gi < 0 && chReq[c]) begin
        gi = c;
        eg = N'(1) << c;
      end
    end
    chk("gnt_a", gnt_a, eg);
    chk("gnt_b", gnt_b, eg);
`ifdef MEM_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      chk("count_a", cnt_a[i], m_cnt[i]);
      chk("count_b", cnt_b[i], m_cnt[i]);
    end
`endif
    g_last = eg;

    if (!reset) begin
      model_reset();
    end else begin
      m_we = 1'b0;
      if (gi >= 0) begin
        m_last = gi;
        m_addr = chAddr[gi];
        m_wd   = chWdata[gi];
        m_we   = chWe[gi];
        if (chWe[gi]) begin
          refmem[chAddr[gi][7:0]] = chWdata[gi];
        end else begin
          r_cyc[cyc & 15] = cyc;
          r_ch[cyc & 15]  = gi;
          r_d[cyc & 15]   = refmem[chAddr[gi][7:0]];
          r_va[cyc & 15]  = 1'b1;
          r_vb[cyc & 15]  = 1'b1;
        end
      end
`ifdef MEM_ARB_STATS_EN
      for (int i = 0; i < N; i++) begin
        if (clearStats) m_cnt[i] = 0;
        else if (i == gi && m_cnt[i] < 65535) m_cnt[i]++;
      end
`endif
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Waiting requests are held stable (or occasionally withdrawn); others re-roll.
  task automatic rand_reqs();
    for (int c = 0; c < N; c++) begin
      if (chReq[c] && !g_last[c]) begin
        if ($urandom_range(7) == 0) chReq[c] = 1'b0;
      end else begin
        chReq[c]   = ($urandom_range(3) != 0);
        chWe[c]    = 1'($urandom_range(1));
        chAddr[c]  = {8'($urandom), 4'h0, 4'($urandom)};
        chWdata[c] = 16'($urandom);
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_fail  = 0;
    cyc     = 0;
    g_last  = '0;
    reset   = 1'b0;
    chReq   = '0;
    chWe    = '0;
    chAddr  = '0;
    chWdata = '0;
`ifdef MEM_ARB_STATS_EN
    clearStats = 1'b0;
`endif
    model_reset();
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b1;
    repeat (10) tick();

    // All four channels write continuously, chAddr[i] = i.
    chReq = '1;
    chWe  = '1;
    for (int c = 0; c < N; c++) begin
      chAddr[c]  = AW'(c);
      chWdata[c] = 16'($urandom);
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rot_gnt", gnt_a, N'(1) << (k % 4));
      tick();
      chk("rot_addr", addr_a, k % 4);
      chk("rot_we", we_a, 1'b1);
    end
    chReq = '0;
    chWe  = '0;
    tick();

    // Channel 2 reads 0x0010; completion four cycles after accept.
    chAddr[2] = 16'h0010;
    chReq     = 4'b0100;
    tick();
    chReq = '0;
    repeat (3) tick();
    chk("lat_rvalid", rv_a, 4'b0100);
    chk("lat_rdata", rd_a, 16'hBEEF);
    repeat (2) tick();

    // Channel 1 read, reset pulsed the next cycle: the read must vanish.
    chAddr[1] = 16'h0005;
    chReq     = 4'b0010;
    tick();
    chReq = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (6) tick();
    chReq = '1;
    #1;
    chk("post_rst_gnt", gnt_a, 4'b0001);
    tick();
    chReq = '0;
    repeat (6) tick();

    // Back-to-back reads ch0 then ch3, checked on the READ_LAT=1 instance.
    chAddr[0] = 16'h0021;
    chAddr[3] = 16'h0033;
    chReq     = 4'b0001;
    tick();
    chReq = 4'b1000;
    tick();
    chReq = '0;
    tick();
    chk("b2b_rvalid0", rv_b, 4'b0001);
    chk("b2b_rdata0", rd_b, init_word(16'h21));
    tick();
    chk("b2b_rvalid1", rv_b, 4'b1000);
    chk("b2b_rdata1", rd_b, init_word(16'h33));
    repeat (4) tick();

    // Randomized traffic.
    repeat (400) begin
      rand_reqs();
`ifdef MEM_ARB_STATS_EN
      clearStats = ($urandom_range(49) == 0);
`endif
      tick();
    end
    chReq = '0;
`ifdef MEM_ARB_STATS_EN
    clearStats = 1'b0;
`endif
    repeat (6) tick();

`ifdef MEM_ARB_STATS_EN
    clearStats = 1'b1;
    tick();
    clearStats = 1'b0;
    chk("stats_clear0", cnt_a[0], 16'h0000);
    chWe[0]   = 1'b0;
    chAddr[0] = 16'h0001;
    chReq     = 4'b0001;
    repeat (70000) tick();
    chk("stats_sat", cnt_a[0], 16'hFFFF);
    clearStats = 1'b1;
    tick();
    clearStats = 1'b0;
    chk("stats_clear_wins", cnt_a[0], 16'h0000);
    chReq = '0;
    repeat (6) tick();
`endif

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
